tick_ctrl: RTL and testbench
============================

TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 17, divisor counter width (holds 100000).
REQ-002 SHALL have parameter STEP_W, default 8, step counter width.
REQ-003 SHALL have port clk_in  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_div  input  CNT_W  tick period in clk_in cycles.
REQ-006 SHALL have port cfg_steps  input  STEP_W  ticks per run; 0 = free-run.
REQ-007 SHALL have port start  input  1  run request, sampled each edge.
REQ-008 SHALL have port stop  input  1  abort request, sampled each edge.
REQ-009 SHALL have port tick  output  1  one-cycle enable pulse for the downstream shift register.
REQ-010 SHALL have port busy  output  1  high while state is RUN.
REQ-011 SHALL have port done  output  1  one-cycle pulse on normal run completion.
REQ-012 SHALL have port cfg_err  output  1  one-cycle pulse on rejected start.
REQ-013 SHALL have port step_cnt  output  STEP_W  ticks issued in current or last run.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-015 SHALL, in IDLE with start=1, stop=0, cfg_div>=1, latch cfg_div/cfg_steps, clear divisor counter and step_cnt, enter RUN next edge.
REQ-016 SHALL, in IDLE with start=1 and cfg_div=0, pulse cfg_err one cycle and remain IDLE.
REQ-017 SHALL give stop priority over start when both high in IDLE: no run, no cfg_err.
REQ-018 SHALL ignore start and cfg_* changes while in RUN or DONE (latched values only).
REQ-019 SHALL, with start sampled at edge E0, assert tick first during the cycle after edge E0+D (D = latched cfg_div), then exactly every D cycles; cfg_div=1 gives tick every cycle.
REQ-020 SHALL increment step_cnt in the same cycle tick is asserted; step_cnt wraps modulo 2^STEP_W in free-run.
REQ-021 SHALL, when step_cnt reaches latched cfg_steps (nonzero), go RUN->DONE; done=1 the cycle after the final tick; DONE->IDLE next edge.
REQ-022 SHALL never deassert busy between ticks of one run; busy=0 in DONE.
REQ-023 SHALL, on stop=1 in RUN, go to IDLE next edge, suppress any tick due that cycle, not pulse done, and hold step_cnt.
REQ-024 SHALL, on stop and final-tick coinciding, honour stop: no tick, no done.
REQ-025 SHALL keep divisor counter at 0 outside RUN.

Reset
REQ-026 SHALL, on rst_n=0 at any time, immediately force IDLE, tick=0, busy=0, done=0, cfg_err=0, step_cnt=0, counters and latched config 0.
REQ-027 SHALL, on reset mid-run, issue no further tick or done; first edge after rst_n rises behaves as IDLE.

Structure
REQ-028 SHALL place state encoding constants and CNT_W/STEP_W defaults in shared package tick_pkg.
REQ-029 SHALL implement divisor counting in one sub-module div_cnt (clear, enable, terminal-count output); FSM and step counter in tick_ctrl.
REQ-030 SHALL not generate derived clocks; tick is a clock enable only.

Verification
REQ-031 cfg_div=4, cfg_steps=3, start pulse -> ticks 4 cycles apart, step_cnt 1,2,3, done one cycle after third tick, busy low after.
REQ-032 cfg_div=1, cfg_steps=5 -> five consecutive tick cycles, then done.
REQ-033 cfg_div=0, start -> cfg_err one cycle, busy stays 0, no tick.
REQ-034 cfg_div=10, cfg_steps=0, stop after 35 cycles of RUN -> exactly 3 ticks, no done, step_cnt=3, IDLE.
REQ-035 cfg_div=3, cfg_steps=2, rst_n low 5 cycles after start -> all outputs 0 immediately; new start afterwards runs normally.
REQ-036 start and stop high together in IDLE -> no run; start while busy -> ignored, tick spacing unchanged.

Source files
------------

// File: rtl/tick_pkg.sv
// tick_pkg: shared definitions for the tick controller.
//   - DEF_CNT_W / DEF_STEP_W : default divisor and step counter widths
//   - state_t                : controller state encoding (IDLE, RUN, DONE)
package tick_pkg;

  localparam int DEF_CNT_W  = 17;  // wide enough to hold a divisor of 100000
  localparam int DEF_STEP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_cnt.sv
// div_cnt: divisor counter producing a terminal-count strobe every i_div
// enabled cycles.
//   clk_in  : system clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   i_clr   : synchronous clear to 0 (has priority)
//   i_en    : count enable
//   i_div   : period in cycles (must be >= 1 while enabled)
//   o_tc    : high in the cycle whose closing edge completes one period
module div_cnt
  import tick_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Count runs 0..i_div-1; with i_div=1 the strobe is high every enabled cycle.
  assign o_tc = i_en && (r_cnt == i_div - 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_tc) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_ctrl.sv
// tick_ctrl: run controller issuing a one-cycle clock-enable pulse every
// cfg_div cycles for cfg_steps ticks (0 = free-run), with abort and
// rejected-configuration reporting. All outputs are registered.
//   clk_in    : system clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   cfg_div   : tick period in clk_in cycles (0 rejected)
//   cfg_steps : ticks per run; 0 = free-run
//   start     : run request (sampled in IDLE only)
//   stop      : abort request (wins over start and over a due tick)
//   tick      : one-cycle enable pulse
//   busy      : high while in RUN
//   done      : one-cycle pulse after the final tick of a completed run
//   cfg_err   : one-cycle pulse when start is rejected for cfg_div=0
//   step_cnt  : ticks issued in the current or last run
module tick_ctrl
  import tick_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [STEP_W-1:0] cfg_steps,
  input  logic              start,
  input  logic              stop,
  output logic              tick,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [STEP_W-1:0] step_cnt
);

  state_t              r_state, w_next_state;
  logic [CNT_W-1:0]    r_div, w_div_nxt;
  logic [STEP_W-1:0]   r_steps, w_steps_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic                r_tick, w_tick_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic                w_tc;

  // The divisor only runs in RUN and is held at zero whenever the
  // controller is not going to be in RUN on the next cycle.
  div_cnt #(.CNT_W(CNT_W)) u_div_cnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .i_clr  (w_next_state != ST_RUN),
    .i_en   (r_state == ST_RUN),
    .i_div  (r_div),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_steps <= '0;
      r_step  <= '0;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_div   <= w_div_nxt;
      r_steps <= w_steps_nxt;
      r_step  <= w_step_nxt;
      r_tick  <= w_tick_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_div_nxt    = r_div;
    w_steps_nxt  = r_steps;
    w_step_nxt   = r_step;
    w_tick_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (cfg_div != '0) begin
            w_next_state = ST_RUN;
            w_div_nxt    = cfg_div;
            w_steps_nxt  = cfg_steps;
            w_step_nxt   = '0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort: drop any tick due now, keep step_cnt, no done.
          w_next_state = ST_IDLE;
        end else if (r_steps != '0 && r_step == r_steps) begin
          // Final tick went out last cycle; a due tick (cfg_div=1) is dropped.
          w_next_state = ST_DONE;
          w_done_nxt   = 1'b1;
        end else if (w_tc) begin
          w_tick_nxt = 1'b1;
          w_step_nxt = r_step + 1'b1;  // wraps naturally in free-run
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_next_state == ST_RUN);
  end

  assign tick     = r_tick;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_err;
  assign step_cnt = r_step;

endmodule

// File: tb/tb_tick_ctrl.sv
// tb_tick_ctrl: directed self-checking bench for tick_ctrl.
// Observation point is 1 ns after each rising edge; k counts edges after
// the edge that sampled start (k=0 is the launch edge itself).
module tb_tick_ctrl;
  import tick_pkg::*;

  localparam int CNT_W  = DEF_CNT_W;
  localparam int STEP_W = DEF_STEP_W;
  localparam int OW     = 4 + STEP_W;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [STEP_W-1:0] cfg_steps = '0;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic              tick, busy, done, cfg_err;
  logic [STEP_W-1:0] step_cnt;

  logic [OW-1:0]     obs;
  int                checks = 0;
  int                errors = 0;

  tick_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_div   (cfg_div),
    .cfg_steps (cfg_steps),
    .start     (start),
    .stop      (stop),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .step_cnt  (step_cnt)
  );

  always #5 clk_in = ~clk_in;

  assign obs = {tick, busy, done, cfg_err, step_cnt};

  function automatic logic [OW-1:0] pack(input bit t, input bit b, input bit d,
                                         input bit e, input int s);
    logic [STEP_W-1:0] sv;
    sv = STEP_W'(s);
    return {t, b, d, e, sv};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Present a one-edge start request; returns at the k=0 observation point.
  task automatic launch(input int div, input int steps);
    cfg_div   = CNT_W'(div);
    cfg_steps = STEP_W'(steps);
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp;
    rst_n = 1'b0;
    cyc();
    cyc();
    exp = pack(0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_hold: got t/b/d/e=%b step=%0d, expected %b step=%0d",
               obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
    end
    #2 rst_n = 1'b1;
    cyc();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_release: got t/b/d/e=%b step=%0d, expected %b step=%0d",
               obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
    end
  endtask

  // div=4, steps=3: ticks at k=4,8,12, done at k=13, idle at k=14.
  task automatic test_basic();
    logic [OW-1:0] exp;
    launch(4, 3);
    for (int k = 0; k <= 14; k++) begin
      exp = pack(k > 0 && k % 4 == 0 && k <= 12, k <= 12, k == 13, 0,
                 (k >= 12) ? 3 : k / 4);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic k=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d", k,
                 obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
      end
      cyc();
    end
  endtask

  // div=1, steps=5: ticks at k=1..5, done at k=6.
  task automatic test_div1();
    logic [OW-1:0] exp;
    launch(1, 5);
    for (int k = 0; k <= 7; k++) begin
      exp = pack(k >= 1 && k <= 5, k <= 5, k == 6, 0, (k <= 5) ? k : 5);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL div1 k=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d", k,
                 obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
      end
      cyc();
    end
  endtask

  // div=0 rejected: one cfg_err pulse, step_cnt keeps 5 from the previous run.
  task automatic test_cfg_err();
    logic [OW-1:0] exp;
    launch(0, 3);
    for (int k = 0; k <= 3; k++) begin
      exp = pack(0, 0, 0, k == 0, 5);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL cfg_err k=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d", k,
                 obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
      end
      cyc();
    end
  endtask

  // div=10 free-run, stop after 35 cycles of RUN: 3 ticks, no done.
  task automatic test_stop_freerun();
    logic [OW-1:0] exp;
    int ticks = 0;
    int extra = 0;
    launch(10, 0);
    for (int k = 0; k < 35; k++) begin
      cyc();
      if (tick === 1'b1) ticks++;
    end
    exp = pack(0, 1, 0, 0, 3);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL freerun_k35: got t/b/d/e=%b step=%0d, expected %b step=%0d",
               obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    exp = pack(0, 0, 0, 0, 3);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL freerun_stopped: got t/b/d/e=%b step=%0d, expected %b step=%0d",
               obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
    end
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) extra++;
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL freerun_ticks: got %0d ticks, expected 3", ticks);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL freerun_after_stop: got %0d active cycles, expected 0", extra);
    end
  endtask

  // div=4, steps=2: stop sampled on the edge of the final tick wins.
  task automatic test_stop_final();
    logic [OW-1:0] exp;
    launch(4, 2);
    for (int k = 1; k <= 7; k++) cyc();
    exp = pack(0, 1, 0, 0, 1);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stopfinal_k7: got t/b/d/e=%b step=%0d, expected %b step=%0d",
               obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int k = 8; k <= 9; k++) begin
      exp = pack(0, 0, 0, 0, 1);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stopfinal k=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d", k,
                 obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
      end
      cyc();
    end
  endtask

  // div=3, steps=2: reset 5 cycles in, then a clean rerun.
  task automatic test_reset_mid();
    logic [OW-1:0] exp;
    launch(3, 2);
    for (int k = 1; k <= 5; k++) cyc();
    exp = pack(0, 1, 0, 0, 1);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rstmid_k5: got t/b/d/e=%b step=%0d, expected %b step=%0d",
               obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
    end
    rst_n = 1'b0;
    #1;
    exp = pack(0, 0, 0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rstmid_async: got t/b/d/e=%b step=%0d, expected %b step=%0d",
               obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
    end
    cyc();
    cyc();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rstmid_quiet c=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d", k,
                 obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
      end
    end
    launch(3, 2);
    for (int k = 0; k <= 8; k++) begin
      exp = pack(k == 3 || k == 6, k <= 6, k == 7, 0, (k < 3) ? 0 : (k < 6) ? 1 : 2);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rstmid_rerun k=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d", k,
                 obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
      end
      cyc();
    end
  endtask

  // start+stop together in IDLE: no run, and no cfg_err even for cfg_div=0.
  task automatic test_start_stop();
    logic [OW-1:0] exp;
    exp = pack(0, 0, 0, 0, 2);
    for (int v = 0; v < 2; v++) begin
      cfg_div   = (v == 0) ? CNT_W'(5) : '0;
      cfg_steps = STEP_W'(4);
      start     = 1'b1;
      stop      = 1'b1;
      cyc();
      start     = 1'b0;
      stop      = 1'b0;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL start_stop v=%0d k=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d",
                   v, k, obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
        end
        cyc();
      end
    end
  endtask

  // div=4, steps=3 with a start + new config mid-run and a start in DONE.
  task automatic test_back_to_back();
    logic [OW-1:0] exp;
    launch(4, 3);
    for (int k = 0; k <= 15; k++) begin
      exp = pack(k > 0 && k % 4 == 0 && k <= 12, k <= 12, k == 13, 0,
                 (k >= 12) ? 3 : k / 4);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b k=%0d: got t/b/d/e=%b step=%0d, expected %b step=%0d", k,
                 obs[OW-1:STEP_W], obs[STEP_W-1:0], exp[OW-1:STEP_W], exp[STEP_W-1:0]);
      end
      if (k == 2) begin
        start     = 1'b1;
        cfg_div   = CNT_W'(1);
        cfg_steps = STEP_W'(7);
      end
      if (k == 3)  start = 1'b0;
      if (k == 13) start = 1'b1;  // sampled while in DONE
      if (k == 14) start = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_div1();
    test_cfg_err();
    test_stop_freerun();
    test_stop_final();
    test_reset_mid();
    test_start_stop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
